writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final stage of the barrel pipeline; sits directly downstream of the memory stage and consumes its outputs.
- Registers the M-stage bundle into W.
- Selects the writeback value (ALU / load data / PC+4).
- Produces the per-thread register-file write request.
- Keeps a per-thread retired-instruction counter readable through a side port.

Parameters:
- ADDRESS_WIDTH, 32, width of PC values.
- DATA_WIDTH, 32, width of datapath values.
- NUM_THREADS, 8, number of hardware threads (need not be a power of 2).
- BITS_THREADS, $clog2(NUM_THREADS), thread-ID width.
- CNT_WIDTH, 32, width of each retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid_m  input  1  M-stage slot holds a live instruction
- reg_write_m  input  1  instruction writes rd
- result_src_m  input  2  writeback source select
- alu_result_m  input  DATA_WIDTH  ALU result from M
- read_data_m  input  DATA_WIDTH  load data from M (already sign/zero-extended)
- rd_m  input  5  destination register
- pc_plus4_m  input  ADDRESS_WIDTH  PC+4 for JAL/JALR link
- tid_m  input  BITS_THREADS  owning thread
- valid_w  output  1  W slot live
- reg_write_w  output  1  register-file write enable
- rd_w  output  5  register-file write address
- result_w  output  DATA_WIDTH  register-file write data
- tid_w  output  BITS_THREADS  register-file bank select
- cnt_tid_r  input  BITS_THREADS  counter read select
- cnt_value_r  output  CNT_WIDTH  counter value for cnt_tid_r
- cnt_clear  input  1  synchronous clear of all counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid_w, reg_write_w, rd_w, result_w, tid_w all go to 0.
  - All counters go to 0.
  - Any in-flight W instruction is discarded and not counted.
- Release is synchronous to clk. The first capture is on the first rising edge with rst_n high.
- Latency:
  - Exactly 1 cycle from M inputs to W outputs.
  - The stage register captures on every rising edge; there is no stall or enable.
  - Each cycle's M slot belongs to a different thread; no forwarding or hazard logic.
- Result selection, done before the register so result_w comes straight from a flop:
  - result_src 00 selects alu_result_m.
  - 01 selects read_data_m.
  - 10 selects pc_plus4_m, zero-extended or truncated to DATA_WIDTH.
  - 11 is reserved: result 0 and the write is suppressed.
- Write enable:
  - reg_write_w = registered (valid_m AND reg_write_m AND rd_m != 0 AND result_src_m != 11).
  - Writes to x0 never leave the stage.
- valid_w = registered valid_m. It is independent of the write-enable suppression.
- Counters:
  - On a rising edge with valid_m=1 and tid_m < NUM_THREADS, counter[tid_m] increments by 1.
  - Counters wrap modulo 2^CNT_WIDTH.
  - Counting happens at capture, so a valid instruction is counted even when reg_write is 0 (stores, branches).
- cnt_clear:
  - Clears all counters on the edge.
  - If a clear and an increment occur on the same edge, clear wins: the result is 0 and that retirement is lost.
- Out-of-range tid (tid >= NUM_THREADS):
  - Stage data still passes through.
  - No counter increments.
  - cnt_value_r reads 0 for an out-of-range cnt_tid_r.
- cnt_value_r:
  - Combinational read of counter[cnt_tid_r].
  - Shows the pre-edge value; an increment becomes visible the cycle after capture.

Decomposition:
- Shared pipeline package holds:
  - result_src encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSVD=2'b11.
  - REG_ZERO=5'd0.
  - The NUM_THREADS/BITS_THREADS defaults, shared with the other stages.
- One sub-module: thread_instret_counters.
  - Counter array with increment, clear and read port, parameterised by NUM_THREADS and CNT_WIDTH.
  - writeback_stage holds only the stage register, the result mux and the write-enable logic.

Test Plan:
- Reset mid-stream:
  - Stimulus: drive valid_m=1, tid=3 for 3 cycles, then pulse rst_n low between edges.
  - Required response: outputs go to 0 immediately and counter[3] reads 0 after reset.
- Source select:
  - Stimulus: alu=0x11, mem=0x22, pc4=0x33, rd=5, reg_write=1; step result_src through 00, 01, 10, 11.
  - Required response, one cycle later: result_w = 0x11, 0x22, 0x33, 0; reg_write_w = 1, 1, 1, 0.
- x0 suppression:
  - Stimulus: rd_m=0, reg_write_m=1, valid_m=1.
  - Required response: reg_write_w=0, valid_w=1, and counter[tid] still increments.
- Round-robin counting:
  - Stimulus: valid_m=1 with tid cycling 0..7 for 24 cycles.
  - Required response: every counter reads 3; the cycle after a capture shows the incremented value on cnt_value_r.
- Clear collision:
  - Stimulus: counter[2]=5; assert cnt_clear on the same edge as valid_m=1, tid=2.
  - Required response: counter[2]=0 next cycle.
- Wrap:
  - Stimulus: CNT_WIDTH=4, 16 valid cycles on tid 1.
  - Required response: counter[1]=0.
- Non-power-of-2 threads:
  - Stimulus: NUM_THREADS=6, valid_m=1 with tid=7.
  - Required response: no counter changes; cnt_tid_r=7 reads 0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions used by the writeback stage and its
// retired-instruction counter block.
//
// Contents:
//   RES_*              writeback source select encodings
//   REG_ZERO           architectural x0 register index
//   DEF_NUM_THREADS    default hardware thread count shared across stages
//   DEF_BITS_THREADS   default thread-ID width shared across stages
package writeback_stage_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_RSVD = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_NUM_THREADS  = 8;
    localparam int DEF_BITS_THREADS = $clog2(DEF_NUM_THREADS);

endpackage

// File: rtl/writeback_stage_counters.sv
// thread_instret_counters: one retired-instruction counter per hardware thread.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (all counters to 0)
//   inc_valid    increment counter[inc_tid] on this edge
//   inc_tid      thread whose counter increments; out-of-range IDs are ignored
//   clear        synchronous clear of every counter; wins over an increment
//   rd_tid       read select
//   rd_value     combinational counter[rd_tid], 0 for an out-of-range rd_tid
//
// Counters wrap modulo 2^CNT_WIDTH. The read port shows the value held in the
// flops, so an increment is visible on the cycle after its edge.
module thread_instret_counters
    import writeback_stage_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_valid,
    input  logic [BITS_THREADS-1:0] inc_tid,
    input  logic                    clear,
    input  logic [BITS_THREADS-1:0] rd_tid,
    output logic [CNT_WIDTH-1:0]    rd_value
);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_THREADS];

    logic inc_in_range;
    logic rd_in_range;

    // With a non-power-of-2 thread count some encodable IDs have no counter.
    assign inc_in_range = int'(inc_tid) < NUM_THREADS;
    assign rd_in_range  = int'(rd_tid) < NUM_THREADS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clear) begin
            // Clear takes priority; a retirement on the same edge is lost.
            for (int i = 0; i < NUM_THREADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_valid && inc_in_range) begin
            cnt_q[inc_tid] <= cnt_q[inc_tid] + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rd_value = '0;
        if (rd_in_range) begin
            rd_value = cnt_q[rd_tid];
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the barrel pipeline.
//
// Registers the memory-stage bundle into W, selects the writeback value and
// produces the per-thread register-file write request. A per-thread
// retired-instruction counter is readable through a side port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_m           M slot holds a live instruction
//   reg_write_m       instruction writes rd
//   result_src_m      writeback source (ALU / load data / PC+4 / reserved)
//   alu_result_m      ALU result
//   read_data_m       load data, already extended
//   rd_m              destination register
//   pc_plus4_m        link value for JAL/JALR
//   tid_m             owning thread
//   valid_w           W slot live
//   reg_write_w       register-file write enable
//   rd_w, result_w    register-file write address / data
//   tid_w             register-file bank select
//   cnt_tid_r         counter read select
//   cnt_value_r       retired count for cnt_tid_r (combinational)
//   cnt_clear         synchronous clear of all counters
//
// Valid semantics: the stage has no backpressure. valid_m qualifies the M
// slot on each rising edge; the slot is captured unconditionally and appears
// on the W outputs exactly one cycle later, qualified by valid_w. reg_write_w
// is a separate qualifier: valid_w may be 1 while the write is suppressed.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_THREADS   = DEF_NUM_THREADS,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_m,
    input  logic                     reg_write_m,
    input  logic [1:0]               result_src_m,
    input  logic [DATA_WIDTH-1:0]    alu_result_m,
    input  logic [DATA_WIDTH-1:0]    read_data_m,
    input  logic [4:0]               rd_m,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    input  logic [BITS_THREADS-1:0]  tid_m,
    output logic                     valid_w,
    output logic                     reg_write_w,
    output logic [4:0]               rd_w,
    output logic [DATA_WIDTH-1:0]    result_w,
    output logic [BITS_THREADS-1:0]  tid_w,
    input  logic [BITS_THREADS-1:0]  cnt_tid_r,
    output logic [CNT_WIDTH-1:0]     cnt_value_r,
    input  logic                     cnt_clear
);

    logic [DATA_WIDTH-1:0] result_sel;
    logic                  write_en_m;

    // Mux sits in front of the register so result_w is driven by a flop.
    always_comb begin
        result_sel = '0;
        case (result_src_m)
            RES_ALU:  result_sel = alu_result_m;
            RES_MEM:  result_sel = read_data_m;
            RES_PC4:  result_sel = DATA_WIDTH'(pc_plus4_m);
            default:  result_sel = '0;
        endcase
    end

    // x0 writes and the reserved source never reach the register file.
    assign write_en_m = valid_m && reg_write_m &&
                        (rd_m != REG_ZERO) && (result_src_m != RES_RSVD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
            rd_w        <= '0;
            result_w    <= '0;
            tid_w       <= '0;
        end else begin
            valid_w     <= valid_m;
            reg_write_w <= write_en_m;
            rd_w        <= rd_m;
            result_w    <= result_sel;
            tid_w       <= tid_m;
        end
    end

    // Retirement is counted at capture, independent of the write enable.
    thread_instret_counters #(
        .NUM_THREADS  (NUM_THREADS),
        .BITS_THREADS (BITS_THREADS),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_counters (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_valid (valid_m),
        .inc_tid   (tid_m),
        .clear     (cnt_clear),
        .rd_tid    (cnt_tid_r),
        .rd_value  (cnt_value_r)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage. A main instance uses the default parameters;
// a second instance (6 threads, 4-bit counters) shares the M-stage inputs and
// covers counter wrap and out-of-range thread IDs.
module tb_writeback_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  tid;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        valid_m = 1'b0;
    logic        reg_write_m = 1'b0;
    logic [1:0]  result_src_m = 2'b00;
    logic [31:0] alu_result_m = '0;
    logic [31:0] read_data_m = '0;
    logic [4:0]  rd_m = '0;
    logic [31:0] pc_plus4_m = '0;
    logic [2:0]  tid_m = '0;
    logic [2:0]  cnt_tid_r = '0;
    logic        cnt_clear = 1'b0;
    logic        valid_w, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [2:0]  tid_w;
    logic [31:0] cnt_value_r;

    logic [2:0]  cnt_tid_r6 = '0;
    logic        valid_w6, reg_write_w6;
    logic [4:0]  rd_w6;
    logic [31:0] result_w6;
    logic [2:0]  tid_w6;
    logic [3:0]  cnt_value_r6;

    writeback_stage u_dut (
        .clk (clk), .rst_n (rst_n),
        .valid_m (valid_m), .reg_write_m (reg_write_m),
        .result_src_m (result_src_m), .alu_result_m (alu_result_m),
        .read_data_m (read_data_m), .rd_m (rd_m),
        .pc_plus4_m (pc_plus4_m), .tid_m (tid_m),
        .valid_w (valid_w), .reg_write_w (reg_write_w),
        .rd_w (rd_w), .result_w (result_w), .tid_w (tid_w),
        .cnt_tid_r (cnt_tid_r), .cnt_value_r (cnt_value_r),
        .cnt_clear (cnt_clear)
    );

    writeback_stage #(.NUM_THREADS (6), .CNT_WIDTH (4)) u_dut6 (
        .clk (clk), .rst_n (rst_n),
        .valid_m (valid_m), .reg_write_m (reg_write_m),
        .result_src_m (result_src_m), .alu_result_m (alu_result_m),
        .read_data_m (read_data_m), .rd_m (rd_m),
        .pc_plus4_m (pc_plus4_m), .tid_m (tid_m),
        .valid_w (valid_w6), .reg_write_w (reg_write_w6),
        .rd_w (rd_w6), .result_w (result_w6), .tid_w (tid_w6),
        .cnt_tid_r (cnt_tid_r6), .cnt_value_r (cnt_value_r6),
        .cnt_clear (cnt_clear)
    );

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every live W slot must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && valid_w) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_w: got valid_w=1 expected no output");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("w_reg_write", {31'd0, reg_write_w}, {31'd0, e.we});
                check("w_rd", {27'd0, rd_w}, {27'd0, e.rd});
                check("w_result", result_w, e.res);
                check("w_tid", {29'd0, tid_w}, {29'd0, e.tid});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one live M slot with its hand-computed W response, then capture.
    task automatic issue(input logic rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [2:0] tid,
                         input logic exp_we, input logic [31:0] exp_res);
        exp_t e;
        valid_m      = 1'b1;
        reg_write_m  = rw;
        result_src_m = src;
        alu_result_m = alu;
        read_data_m  = mem;
        pc_plus4_m   = pc4;
        rd_m         = rd;
        tid_m        = tid;
        e.we = exp_we; e.rd = rd; e.res = exp_res; e.tid = tid;
        exp_q.push_back(e);
        sync();
    endtask

    task automatic idle();
        valid_m = 1'b0;
        reg_write_m = 1'b0;
        sync();
    endtask

    task automatic clear_all();
        valid_m = 1'b0;
        cnt_clear = 1'b1;
        sync();
        cnt_clear = 1'b0;
    endtask

    task automatic check_cnt(input string name, input logic [2:0] tid, input logic [31:0] exp);
        cnt_tid_r = tid;
        #1;
        check(name, cnt_value_r, exp);
    endtask

    task automatic check_cnt6(input string name, input logic [2:0] tid, input logic [3:0] exp);
        cnt_tid_r6 = tid;
        #1;
        check(name, {28'd0, cnt_value_r6}, {28'd0, exp});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_w", {31'd0, valid_w}, 32'd0);
        check("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("rst_result_w", result_w, 32'd0);
        check_cnt("rst_cnt0", 3'd0, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        sync();

        // Reset mid-stream: three retirements on thread 3, then async reset
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 2'b00, 32'hA0 + i, 32'h0, 32'h0, 5'd1, 3'd3, 1'b1, 32'hA0 + i);
        end
        valid_m = 1'b0;
        check_cnt("pre_rst_cnt3", 3'd3, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid_w", {31'd0, valid_w}, 32'd0);
        check("mid_rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
        check("mid_rst_rd_w", {27'd0, rd_w}, 32'd0);
        check("mid_rst_result_w", result_w, 32'd0);
        check("mid_rst_tid_w", {29'd0, tid_w}, 32'd0);
        check_cnt("mid_rst_cnt3", 3'd3, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        sync();
        check_cnt("post_rst_cnt3", 3'd3, 32'd0);
        sync();

        // Source select: ALU, load data, PC+4, reserved
        issue(1'b1, 2'b00, 32'h11, 32'h22, 32'h33, 5'd5, 3'd4, 1'b1, 32'h11);
        issue(1'b1, 2'b01, 32'h11, 32'h22, 32'h33, 5'd5, 3'd4, 1'b1, 32'h22);
        issue(1'b1, 2'b10, 32'h11, 32'h22, 32'h33, 5'd5, 3'd4, 1'b1, 32'h33);
        issue(1'b1, 2'b11, 32'h11, 32'h22, 32'h33, 5'd5, 3'd4, 1'b0, 32'h0);
        // Store-like slot: no write, still live and still counted
        issue(1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd9, 3'd4, 1'b0, 32'hDEAD_BEEF);
        idle();
        check_cnt("src_cnt4", 3'd4, 32'd5);

        // x0 suppression
        issue(1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd0, 3'd6, 1'b0, 32'h55);
        idle();
        check_cnt("x0_cnt6", 3'd6, 32'd1);
        sync();

        // Round-robin counting: 24 slots over threads 0..7
        clear_all();
        for (int i = 0; i < 24; i++) begin
            issue(1'b1, 2'b01, 32'h0, 32'h1000 + i, 32'h0, 5'((i % 31) + 1),
                  3'(i % 8), 1'b1, 32'h1000 + i);
            if (i % 8 == 5) begin
                check_cnt("rr_next_cycle", 3'(i % 8), 32'(i / 8 + 1));
            end
        end
        idle();
        for (int t = 0; t < 8; t++) begin
            check_cnt("rr_final", 3'(t), 32'd3);
        end
        sync();

        // Clear collision on thread 2
        clear_all();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 2'b00, 32'h200 + i, 32'h0, 32'h0, 5'd7, 3'd2, 1'b1, 32'h200 + i);
        end
        valid_m = 1'b0;
        check_cnt("clr_pre_cnt2", 3'd2, 32'd5);
        sync();
        cnt_clear = 1'b1;
        issue(1'b1, 2'b10, 32'h0, 32'h0, 32'h0000_0404, 5'd1, 3'd2, 1'b1, 32'h0000_0404);
        cnt_clear = 1'b0;
        idle();
        check_cnt("clr_collide_cnt2", 3'd2, 32'd0);
        check_cnt("clr_collide_cnt7", 3'd7, 32'd0);
        sync();

        // Wrap with 4-bit counters on thread 1
        clear_all();
        for (int i = 0; i < 15; i++) begin
            issue(1'b1, 2'b00, 32'h300 + i, 32'h0, 32'h0, 5'd3, 3'd1, 1'b1, 32'h300 + i);
        end
        valid_m = 1'b0;
        check_cnt6("wrap_pre_cnt1", 3'd1, 4'd15);
        sync();
        issue(1'b1, 2'b00, 32'h30F, 32'h0, 32'h0, 5'd3, 3'd1, 1'b1, 32'h30F);
        idle();
        check_cnt6("wrap_cnt1", 3'd1, 4'd0);
        check_cnt("wide_cnt1", 3'd1, 32'd16);
        sync();

        // Out-of-range thread IDs on the 6-thread instance
        issue(1'b1, 2'b00, 32'h400, 32'h0, 32'h0, 5'd4, 3'd0, 1'b1, 32'h400);
        issue(1'b1, 2'b00, 32'h401, 32'h0, 32'h0, 5'd4, 3'd7, 1'b1, 32'h401);
        check("oor_tid_w6", {29'd0, tid_w6}, 32'd7);
        check("oor_result_w6", result_w6, 32'h401);
        issue(1'b1, 2'b00, 32'h402, 32'h0, 32'h0, 5'd4, 3'd7, 1'b1, 32'h402);
        issue(1'b1, 2'b00, 32'h403, 32'h0, 32'h0, 5'd4, 3'd6, 1'b1, 32'h403);
        idle();
        check_cnt6("oor_cnt0", 3'd0, 4'd1);
        check_cnt6("oor_cnt1", 3'd1, 4'd0);
        check_cnt6("oor_cnt5", 3'd5, 4'd0);
        check_cnt6("oor_read7", 3'd7, 4'd0);
        check_cnt6("oor_read6", 3'd6, 4'd0);
        check_cnt("wide_cnt7", 3'd7, 32'd2);
        check_cnt("wide_cnt6", 3'd6, 32'd1);

        // Drain and final report
        sync();
        sync();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
